// File: rtl/uart_rx_if.sv
// Receive-side bundle of the 8N1 UART receiver: byte, valid/frame-error pulses, busy.
// master = the receiver that drives it, slave = the command/decoder logic that consumes it.
interface uart_rx_if;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_busy;

  modport master (
    output rx_byte,
    output rx_valid,
    output rx_frame_err,
    output rx_busy
  );

  modport slave (
    input rx_byte,
    input rx_valid,
    input rx_frame_err,
    input rx_busy
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit start check, LSB-first data, stop check.
// Optional macro UART_RX_MAJORITY_EN: 2-of-3 vote around each sample point, decided one cycle later.
module uart_rx #(
  parameter int CLOCK_FREQUENCY = 50_000_000,
  parameter int BAUD_RATE       = 115200
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx_serial,
  uart_rx_if.master  rx
);

  localparam int CLKS_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);

`ifdef UART_RX_MAJORITY_EN
  localparam int START_TGT = HALF_BIT;
`else
  localparam int START_TGT = HALF_BIT - 1;
`endif

  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TGT);
  localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);

  generate
    if (CLKS_PER_BIT < 8) begin : g_bad_rate
      $error("uart_rx: CLKS_PER_BIT must be at least 8");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [1:0]       sync_reg;
  logic             rx_s;
  logic             sample;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic [2:0]       bit_idx_reg;
  logic [2:0]       bit_idx_next;
  logic [7:0]       shift_reg;
  logic [7:0]       shift_next;
  logic [7:0]       byte_reg;
  logic [7:0]       byte_next;
  logic             valid_reg;
  logic             valid_next;
  logic             err_reg;
  logic             err_next;
  logic             capture;

  // Both flops reset to the idle level so reset never looks like a start edge.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sync_reg <= 2'b11;
    end else begin
      sync_reg <= {sync_reg[0], i_rx_serial};
    end
  end

  assign rx_s = sync_reg[1];

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_reg;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      hist_reg <= 2'b11;
    end else begin
      hist_reg <= {hist_reg[0], rx_s};
    end
  end

  // Counter at the decision point is target+1, so hist holds target and target-1.
  assign sample = (rx_s & hist_reg[0]) | (rx_s & hist_reg[1]) | (hist_reg[0] & hist_reg[1]);
`else
  assign sample = rx_s;
`endif

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_shift
      assign shift_next[gi] = (capture && (bit_idx_reg == 3'(gi))) ? sample : shift_reg[gi];
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      bit_idx_reg <= 3'd0;
      shift_reg   <= 8'h00;
      byte_reg    <= 8'h00;
      valid_reg   <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      bit_idx_reg <= bit_idx_next;
      shift_reg   <= shift_next;
      byte_reg    <= byte_next;
      valid_reg   <= valid_next;
      err_reg     <= err_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg + CNT_W'(1);
    bit_idx_next = bit_idx_reg;
    byte_next    = byte_reg;
    valid_next   = 1'b0;
    err_next     = 1'b0;
    capture      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (!rx_s) begin
          state_next = START;
        end
      end

      START: begin
        if (cnt_reg == START_LAST) begin
          bit_idx_next = 3'd0;
          state_next   = sample ? IDLE : DATA;
        end
      end

      DATA: begin
        if (cnt_reg == BIT_LAST) begin
          capture  = 1'b1;
          // The bit period has to restart here even without a state change.
          cnt_next = '0;
          if (bit_idx_reg == 3'd7) begin
            state_next = STOP;
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
          end
        end
      end

      STOP: begin
        if (cnt_reg == BIT_LAST) begin
          if (sample) begin
            byte_next  = shift_reg;
            valid_next = 1'b1;
            state_next = IDLE;
          end else begin
            err_next   = 1'b1;
            state_next = WAIT_IDLE;
          end
        end
      end

      WAIT_IDLE: begin
        if (rx_s) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    if (state_next != state_reg) begin
      cnt_next = '0;
    end
  end

  assign rx.rx_byte      = byte_reg;
  assign rx.rx_valid     = valid_reg;
  assign rx.rx_frame_err = err_reg;
  assign rx.rx_busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a frame-level expectation queue is checked every cycle.
// Build with UART_RX_MAJORITY_EN defined to also exercise the mid-bit glitch case.
module tb_uart_rx;

  localparam int CF   = 1_600_000;
  localparam int BR   = 100_000;
  localparam int CPB  = CF / BR;
  localparam int HALF = CPB / 2;
  localparam int NOM  = 100 * CPB;

`ifdef UART_RX_MAJORITY_EN
  localparam int LAT_SPEC = 2 + HALF + 9 * CPB + 1;
  localparam int PIN_LAT  = 156;
`else
  localparam int LAT_SPEC = 2 + HALF + 9 * CPB;
  localparam int PIN_LAT  = 155;
`endif

  logic i_clk       = 1'b0;
  logic i_rst_n     = 1'b0;
  logic i_rx_serial = 1'b1;

  uart_rx_if rx ();

  uart_rx #(
    .CLOCK_FREQUENCY(CF),
    .BAUD_RATE      (BR)
  ) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_rx_serial(i_rx_serial),
    .rx         (rx)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         t0;
  } exp_t;

  exp_t       exp_q[$];
  int         checks     = 0;
  int         failures   = 0;
  int         cyc        = 0;
  int         valid_cnt  = 0;
  int         err_cnt    = 0;
  int         last_lat   = -1;
  int         busy_runs  = 0;
  bit         meas_en    = 1'b0;
  logic [7:0] model_byte = 8'h00;
  logic       rst_q      = 1'b0;
  logic       prev_valid = 1'b0;
  logic       prev_err   = 1'b0;
  logic       prev_busy  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  always @(posedge i_clk) begin
    rst_q <= i_rst_n;
    cyc   <= cyc + 1;
  end

  // Per-cycle comparison against the frame-level expectation queue.
  always @(negedge i_clk) begin : cmp
    exp_t e;
    int   lat;
    if (!rst_q) begin
      exp_q.delete();
      model_byte = 8'h00;
      check("reset_outputs", {21'd0, rx.rx_byte, rx.rx_valid, rx.rx_frame_err, rx.rx_busy}, 32'd0);
    end else begin
      check("valid_err_exclusive", 32'(rx.rx_valid & rx.rx_frame_err), 32'd0);
      check("pulse_width", 32'((rx.rx_valid & prev_valid) | (rx.rx_frame_err & prev_err)), 32'd0);
      if (rx.rx_valid || rx.rx_frame_err) begin
        if (rx.rx_valid) valid_cnt++;
        else err_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_pulse: got valid=%0b err=%0b byte=%02h required no pulse",
                   rx.rx_valid, rx.rx_frame_err, rx.rx_byte);
        end else begin
          e        = exp_q.pop_front();
          lat      = cyc - e.t0;
          last_lat = lat;
          check("pulse_kind_err", 32'(rx.rx_frame_err), 32'(e.is_err));
          if (!e.is_err) begin
            check("byte_on_valid", 32'(rx.rx_byte), 32'(e.data));
            model_byte = e.data;
          end
          checks++;
          if (lat < LAT_SPEC - 1 || lat > LAT_SPEC + 1) begin
            failures++;
            $display("FAIL latency: got %0d required %0d +-1", lat, LAT_SPEC);
          end
          $display("rx %s byte=%02h expected=%02h latency=%0d",
                   e.is_err ? "frame_err" : "valid", rx.rx_byte, e.data, lat);
        end
      end
      check("byte_held", 32'(rx.rx_byte), 32'(model_byte));
      if (exp_q.size() > 0 && cyc > exp_q[0].t0 + LAT_SPEC + 3) begin
        checks++;
        failures++;
        $display("FAIL missing_pulse: got none required %s byte=%02h",
                 exp_q[0].is_err ? "frame_err" : "valid", exp_q[0].data);
        void'(exp_q.pop_front());
      end
      if (meas_en && prev_busy && !rx.rx_busy) busy_runs++;
    end
    prev_valid = rx.rx_valid;
    prev_err   = rx.rx_frame_err;
    prev_busy  = rx.rx_busy;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
      i_rx_serial = 1'b1;
    end
  endtask

  task automatic hold_low(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
      i_rx_serial = 1'b0;
    end
  endtask

  // len_x100: transmitter bit length in hundredths of a clock; glitch_n / rst_at < 0 disables.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int len_x100,
                            input int glitch_n, input int rst_at, input bit expect_evt);
    int   n;
    int   idx;
    logic v;
    n = 0;
    forever begin
      idx = (n * 100) / len_x100;
      if (idx >= 10) break;
      if (idx == 0) v = 1'b0;
      else if (idx == 9) v = stop_bit;
      else v = d[idx-1];
      if (n == glitch_n) v = ~v;
      @(posedge i_clk);
      #1;
      if (n == 0 && expect_evt) exp_q.push_back('{is_err: !stop_bit, data: d, t0: cyc});
      i_rx_serial = v;
      if (rst_at >= 0) i_rst_n = !(n >= rst_at && n < rst_at + 2);
      n++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] b2b [4];
    b2b[0] = 8'h00; b2b[1] = 8'hFF; b2b[2] = 8'h55; b2b[3] = 8'h3C;

    repeat (5) @(posedge i_clk);
    #1;
    check("reset_byte", 32'(rx.rx_byte), 32'h00);
    check("reset_valid", 32'(rx.rx_valid), 32'd0);
    check("reset_busy", 32'(rx.rx_busy), 32'd0);
    i_rst_n = 1'b1;
    idle(20);

    send_frame(8'hA5, 1'b1, NOM, -1, -1, 1'b1);
    idle(40);
    check("a5_latency", 32'(last_lat), 32'(PIN_LAT));
    check("a5_byte", 32'(rx.rx_byte), 32'hA5);
    check("a5_valid_count", 32'(valid_cnt), 32'd1);
    check("a5_err_count", 32'(err_cnt), 32'd0);

    meas_en = 1'b1;
    for (int i = 0; i < 4; i++) send_frame(b2b[i], 1'b1, NOM, -1, -1, 1'b1);
    idle(40);
    meas_en = 1'b0;
    check("b2b_valid_count", 32'(valid_cnt), 32'd5);
    check("b2b_last_byte", 32'(rx.rx_byte), 32'h3C);
    check("b2b_busy_dips", 32'(busy_runs), 32'd4);

    hold_low(4);
    @(posedge i_clk);
    #1;
    i_rx_serial = 1'b1;
    check("glitch_busy_seen", 32'(rx.rx_busy), 32'd1);
    repeat (8) @(posedge i_clk);
    #1;
    check("glitch_back_idle", 32'(rx.rx_busy), 32'd0);
    idle(40);
    check("glitch_valid_count", 32'(valid_cnt), 32'd5);
    check("glitch_err_count", 32'(err_cnt), 32'd0);

    send_frame(8'h81, 1'b0, NOM, -1, -1, 1'b1);
    hold_low(20 * CPB);
    check("break_err_count", 32'(err_cnt), 32'd1);
    check("break_byte_kept", 32'(rx.rx_byte), 32'h3C);
    check("break_busy", 32'(rx.rx_busy), 32'd1);
    idle(40);
    check("break_released_idle", 32'(rx.rx_busy), 32'd0);
    send_frame(8'h42, 1'b1, NOM, -1, -1, 1'b1);
    idle(40);
    check("after_break_byte", 32'(rx.rx_byte), 32'h42);
    check("after_break_err_count", 32'(err_cnt), 32'd1);

    send_frame(8'hF5, 1'b1, NOM, -1, 5 * CPB + HALF, 1'b0);
    idle(40);
    check("midframe_rst_valid_count", 32'(valid_cnt), 32'd6);
    check("midframe_rst_byte", 32'(rx.rx_byte), 32'h00);
    send_frame(8'h7E, 1'b1, NOM, -1, -1, 1'b1);
    idle(40);
    check("after_rst_byte", 32'(rx.rx_byte), 32'h7E);

    send_frame(8'hC3, 1'b1, (NOM * 100) / 103, -1, -1, 1'b1);
    idle(40);
    check("fast_baud_byte", 32'(rx.rx_byte), 32'hC3);
    send_frame(8'h00, 1'b1, NOM, -1, -1, 1'b1);
    idle(40);
    send_frame(8'hC3, 1'b1, (NOM * 100) / 97, -1, -1, 1'b1);
    idle(40);
    check("slow_baud_byte", 32'(rx.rx_byte), 32'hC3);
    check("baud_valid_count", 32'(valid_cnt), 32'd10);

`ifdef UART_RX_MAJORITY_EN
    send_frame(8'h00, 1'b1, NOM, -1, -1, 1'b1);
    idle(40);
    send_frame(8'hC3, 1'b1, NOM, 3 * CPB + HALF, -1, 1'b1);
    idle(40);
    check("majority_glitch_byte", 32'(rx.rx_byte), 32'hC3);
    check("majority_valid_count", 32'(valid_cnt), 32'd12);
`endif

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
